pi_tx_scheduler: RTL and testbench

- Arbitrates between N_CH voltage producers that share the single SPI-to-Pi sender, using round-robin.
- Converts the granted two's-complement sample to the sender's 11-bit sign-magnitude format.
- Drives the sender's start line with the timing that the sclk-domain sender needs: start held high across several sclk negedges, and a full 16-bit frame elapsed before the next start.
- Runs on the system clock; the sender runs on sclk.

---
 rtl/pi_tx_scheduler.sv | 141 ++++++++++++++
 tb/tb_pi_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_tx_scheduler.sv
// rtl/pi_tx_scheduler.sv - round-robin scheduler feeding the shared SPI-to-Pi sender
// Grants one producer per frame, converts its sample to sign-magnitude and paces start.
module pi_tx_scheduler #(
  parameter int N_CH        = 4,
  parameter int SCLK_DIV    = 64,
  parameter int HOLD_SCLKS  = 2,
  parameter int FRAME_SCLKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_CH-1:0]      req,
  input  logic [11*N_CH-1:0]   sample_in,
  output logic [N_CH-1:0]      ack,
  output logic [10:0]          voltage,
  output logic                 start,
  output logic                 busy,
  output logic [2:0]           ch_sel,
  output logic                 sat
);

  localparam int CW = $clog2(FRAME_SCLKS * SCLK_DIV + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_SCLKS * SCLK_DIV - 1);
  // One cycle shorter than the remaining frame: the IDLE grant cycle closes the period.
  localparam logic [CW-1:0] WAIT_LAST = CW'((FRAME_SCLKS - HOLD_SCLKS) * SCLK_DIV - 2);

  typedef enum logic [1:0] {IDLE, START_HI, WAIT} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count, count_next;
  logic [2:0]        ptr;
  logic              grant;

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic              grant_found;
  logic [3:0]        grant_off, grant_sum, ptr_sum;
  logic [2:0]        grant_idx, ptr_next;
  logic [10:0]       sel_sample, neg_sample, conv_val;
  logic              conv_sat;

  // Rotate requests so bit 0 is the pointer channel; the lowest set bit wins.
  always_comb begin
    req_dbl     = {req, req};
    req_rot     = N_CH'(req_dbl >> ptr);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_found && req_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = 4'(k);
      end
    end
    grant_sum = {1'b0, ptr} + grant_off;
    if (grant_sum >= 4'(N_CH)) grant_sum = grant_sum - 4'(N_CH);
    grant_idx = grant_sum[2:0];
    ptr_sum   = {1'b0, grant_idx} + 4'd1;
    if (ptr_sum == 4'(N_CH)) ptr_sum = '0;
    ptr_next  = ptr_sum[2:0];
  end

  always_comb begin
    sel_sample = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == 3'(i)) sel_sample = sample_in[11*i +: 11];
    end
    neg_sample = -sel_sample;
    conv_sat   = (sel_sample == 11'h400);
    if (!sel_sample[10])  conv_val = {1'b0, sel_sample[9:0]};
    else if (conv_sat)    conv_val = 11'h7FF;
    else                  conv_val = {1'b1, neg_sample[9:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && grant_found) begin
          grant      = 1'b1;
          state_next = START_HI;
          count_next = '0;
        end
      end
      START_HI: begin
        if (count == HOLD_LAST) begin
          state_next = WAIT;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      WAIT: begin
        if (count == WAIT_LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so start/busy align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack     <= '0;
      voltage <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      ch_sel  <= '0;
      sat     <= 1'b0;
      ptr     <= '0;
    end else begin
      ack   <= '0;
      sat   <= 1'b0;
      start <= (state_next == START_HI);
      busy  <= (state_next != IDLE);
      if (grant) begin
        voltage <= conv_val;
        ack     <= N_CH'(1) << grant_idx;
        ch_sel  <= grant_idx;
        ptr     <= ptr_next;
        sat     <= conv_sat;
      end
    end
  end

endmodule

// File: tb/tb_pi_tx_scheduler.sv
// tb/tb_pi_tx_scheduler.sv - directed bench for pi_tx_scheduler with an SPI sender model
module tb_pi_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req = '0;
  logic [43:0] sample_in = '0;
  logic [3:0]  ack;
  logic [10:0] voltage;
  logic        start;
  logic        busy;
  logic [2:0]  ch_sel;
  logic        sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pi_tx_scheduler #(.N_CH(4), .SCLK_DIV(4), .HOLD_SCLKS(2), .FRAME_SCLKS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .sample_in(sample_in),
    .ack(ack), .voltage(voltage), .start(start), .busy(busy), .ch_sel(ch_sel), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sender model in the sclk domain: sclk = clk/4, 16-sclk frame, 11 bits MSB-first.
  logic [1:0]  div = '0;
  logic        sclk;
  logic        ncs = 1'b1;
  logic        mosi = 1'b0;
  logic [10:0] shreg = '0;
  logic [10:0] rx = '0;
  int          fc = 0;
  int          rxn = 0;
  logic [10:0] rx_q[$];

  always @(posedge clk) div <= div + 2'd1;
  assign sclk = div[1];

  always @(negedge sclk) begin
    if (fc == 0) begin
      if (start) begin
        fc    <= 1;
        ncs   <= 1'b0;
        mosi  <= voltage[10];
        shreg <= {voltage[9:0], 1'b0};
      end
    end else if (fc < 11) begin
      mosi  <= shreg[10];
      shreg <= shreg << 1;
      fc    <= fc + 1;
    end else if (fc == 11) begin
      ncs <= 1'b1;
      fc  <= fc + 1;
    end else if (fc < 15) begin
      fc <= fc + 1;
    end else begin
      fc <= 0;
    end
  end

  always @(posedge sclk) begin
    if (!ncs) begin
      rx  <= {rx[9:0], mosi};
      rxn <= rxn + 1;
    end else if (rxn == 11) begin
      rx_q.push_back(rx);
      rxn <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps at least one negedge, then waits (bounded) for an ack pulse.
  task automatic wait_ack(input string tag, input int budget, output int lat, output int at);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack === 4'b0000 && lat < budget);
    at = cyc;
    checks++;
    assert (ack !== 4'b0000) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0h expected=nonzero", tag, ack);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  int          lat, t, t_prev, hi, bad;
  int          rr_ch[5]  = '{0, 1, 2, 3, 0};
  logic [10:0] rr_v[5]   = '{11'h401, 11'h7FF, 11'h3FF, 11'h000, 11'h401};
  logic        rr_s[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int          co_ch[4]  = '{2, 3, 0, 1};
  logic [10:0] co_v[4]   = '{11'h200, 11'h401, 11'h12C, 11'h52C};
  logic [3:0]  exp_ack;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_voltage", voltage, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b0;

    // 1. Single request on channel 2
    sample_in = {11'd0, 11'd300, 11'd0, 11'd0};
    req = 4'b0100;
    wait_ack("t1", 20, lat, t);
    chk("t1_latency", lat, 1);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_ch_sel", ch_sel, 2);
    chk("t1_voltage", voltage, 11'h12C);
    chk("t1_sat", sat, 0);
    req = 4'b0000;
    hi = 0;
    for (int k = 0; k < 64; k++) begin
      if (start === 1'b1) hi++;
      if (k == 1) chk("t1_ack_pulse", ack, 0);
      if (k == 62) chk("t1_busy_62", busy, 1);
      @(negedge clk);
    end
    chk("t1_start_len", hi, 8);
    chk("t1_busy_end", busy, 0);

    // 2+3. Round-robin over all channels with conversion corner samples
    reset = 1'b1;
    req = 4'b1111;
    sample_in = {11'h000, 11'h3FF, 11'h400, 11'h7FF};
    @(negedge clk);
    reset = 1'b0;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack("t2", 100, lat, t);
      exp_ack = 4'b0001 << rr_ch[i];
      chk("t2_ack", ack, exp_ack);
      chk("t2_ch_sel", ch_sel, rr_ch[i]);
      chk("t2_voltage", voltage, rr_v[i]);
      chk("t2_sat", sat, rr_s[i]);
      chk("t2_start", start, 1);
      if (i == 0) chk("t2_latency", lat, 1);
      else chk("t2_period", t - t_prev, 64);
      t_prev = t;
      req[rr_ch[i]] = 1'b0;
      @(negedge clk);
      chk("t2_ack_pulse", ack, 0);
      chk("t2_sat_pulse", sat, 0);
      if (i < 4) req[rr_ch[i]] = 1'b1;
    end
    req = 4'b0000;

    // 4. Enable gating
    wait_idle("t4_idle");
    enable = 1'b0;
    req = 4'b0001;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000 || start !== 1'b0) bad = 1;
    end
    chk("t4_gated", bad, 0);
    enable = 1'b1;
    wait_ack("t4", 20, lat, t);
    chk("t4_latency", lat, 1);
    chk("t4_ack", ack, 4'b0001);
    chk("t4_voltage", voltage, 11'h401);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (start === 1'b1) hi++;
      if (k == 2) enable = 1'b0;
      @(negedge clk);
    end
    chk("t4_start_len", hi, 8);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (ack !== 4'b0000) bad = 1;
    end
    chk("t4_no_regrant", bad, 0);
    chk("t4_busy", busy, 0);

    // 5. Reset mid-frame (pointer left at 3 by the ch2 grant)
    enable = 1'b1;
    req = 4'b0100;
    wait_ack("t5", 20, lat, t);
    chk("t5_ack", ack, 4'b0100);
    chk("t5_voltage", voltage, 11'h3FF);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_start", start, 0);
    chk("t5_rst_voltage", voltage, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_ch_sel", ch_sel, 0);
    req = 4'b1010;
    @(negedge clk);
    reset = 1'b0;
    wait_ack("t5b", 20, lat, t);
    chk("t5_latency", lat, 1);
    chk("t5_ack_ptr0", ack, 4'b0010);
    chk("t5_ch_sel", ch_sel, 1);
    chk("t5_voltage_sat", voltage, 11'h7FF);
    chk("t5_sat", sat, 1);
    req = 4'b0000;

    // 6. Sender co-simulation (pointer at 2)
    wait_idle("t6_idle");
    repeat (80) @(negedge clk);
    rx_q.delete();
    sample_in = {11'h7FF, 11'd512, 11'h6D4, 11'd300};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack("t6", 100, lat, t);
      chk("t6_ch_sel", ch_sel, co_ch[i]);
      req[co_ch[i]] = 1'b0;
    end
    bad = 0;
    while (rx_q.size() < 4 && bad < 400) begin
      @(negedge clk);
      bad++;
    end
    chk("t6_frames", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t6_mosi", (i < rx_q.size()) ? {21'd0, rx_q[i]} : 32'hxxxxxxxx, co_v[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
